// File: rtl/mipi_pll_reset_seq.sv
// Power-up / reset sequencer around the MIPI PLL, clocked by the 50 MHz refclk.
// Holds the PLL in reset, waits for a stable lock, then releases camera
// power-down, the MIPI bridge reset and the downstream system reset in order.
// Retries the PLL on lock timeout and latches a fault when retries run out.
module mipi_pll_reset_seq #(
    parameter int unsigned PLL_RST_CYC      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned LOCK_STABLE_CYC  = 256,
    parameter int unsigned MIPI_RST_CYC     = 1000,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned CNT_W            = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       cam_pwdn,
    output logic       mipi_reset_n,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

    localparam logic [CNT_W-1:0]   PLL_RST_LAST  = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST   = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]   MIPI_LAST     = CNT_W'(MIPI_RST_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT   = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_LOCK_STABLE,
        ST_MIPI_RESET,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_n;
    logic [7:0]         loss_n;

    logic lock_meta;
    logic lock_s;

    logic pll_rst_n;
    logic cam_pwdn_n;
    logic mipi_reset_n_n;
    logic sys_rst_n;
    logic ready_n;
    logic fault_n;

    // Two-flop synchronizer bringing the asynchronous PLL lock into refclk.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Next-state, retry and lock-loss bookkeeping.
    always_comb begin
        state_n = state;
        retry_n = retry;
        loss_n  = lock_loss_cnt;
        case (state)
            ST_PLL_RESET: begin
                if (cnt == PLL_RST_LAST) begin
                    state_n = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a timeout on the same cycle.
                if (lock_s) begin
                    state_n = ST_LOCK_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry == RETRY_LIMIT) begin
                        state_n = ST_FAULT;
                    end else begin
                        retry_n = retry + RETRY_W'(1);
                        state_n = ST_PLL_RESET;
                    end
                end
            end
            ST_LOCK_STABLE: begin
                if (!lock_s) begin
                    state_n = ST_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_n = ST_MIPI_RESET;
                end
            end
            ST_MIPI_RESET, ST_RUN: begin
                if (!lock_s) begin
                    state_n = ST_PLL_RESET;
                    retry_n = '0;
                    if (lock_loss_cnt != '1) begin
                        loss_n = lock_loss_cnt + 8'd1;
                    end
                end else if ((state == ST_MIPI_RESET) && (cnt == MIPI_LAST)) begin
                    state_n = ST_RUN;
                    retry_n = '0;
                end
            end
            ST_FAULT: begin
                state_n = ST_FAULT;
            end
            default: begin
                state_n = ST_PLL_RESET;
            end
        endcase
    end

    // Output decode of the upcoming state so the registered outputs track the state register.
    always_comb begin
        pll_rst_n      = 1'b1;
        cam_pwdn_n     = 1'b1;
        mipi_reset_n_n = 1'b0;
        sys_rst_n      = 1'b1;
        ready_n        = 1'b0;
        fault_n        = 1'b0;
        case (state_n)
            ST_PLL_RESET: begin
                pll_rst_n = 1'b1;
            end
            ST_WAIT_LOCK, ST_LOCK_STABLE: begin
                pll_rst_n = 1'b0;
            end
            ST_MIPI_RESET: begin
                pll_rst_n  = 1'b0;
                cam_pwdn_n = 1'b0;
            end
            ST_RUN: begin
                pll_rst_n      = 1'b0;
                cam_pwdn_n     = 1'b0;
                mipi_reset_n_n = 1'b1;
                sys_rst_n      = 1'b0;
                ready_n        = 1'b1;
            end
            ST_FAULT: begin
                fault_n = 1'b1;
            end
            default: begin
                pll_rst_n = 1'b1;
            end
        endcase
    end

    // State, phase counter, retry/loss counters and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= ST_PLL_RESET;
            cnt           <= '0;
            retry         <= '0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            cam_pwdn      <= 1'b1;
            mipi_reset_n  <= 1'b0;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= (state_n != state) ? '0 : cnt + CNT_W'(1);
            retry         <= retry_n;
            lock_loss_cnt <= loss_n;
            pll_rst       <= pll_rst_n;
            cam_pwdn      <= cam_pwdn_n;
            mipi_reset_n  <= mipi_reset_n_n;
            sys_rst       <= sys_rst_n;
            ready         <= ready_n;
            fault         <= fault_n;
        end
    end

endmodule
